// File: rtl/rgb2ycbcr_pipe_if.sv
// Pixel stream bundle for the RGB->YCbCr converter: RGB input side and YCbCr output side.
`timescale 1ns/1ps
interface rgb2ycbcr_pipe_if #(
  parameter int BPCH_I = 8,
  parameter int BPCH_O = 8
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic              sol_i;
  logic [1:0]        mode_i;
  logic              fmt422_i;
  logic [BPCH_I-1:0] r_i;
  logic [BPCH_I-1:0] g_i;
  logic [BPCH_I-1:0] b_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              sol_o;
  logic [BPCH_O-1:0] y_o;
  logic [BPCH_O-1:0] cb_o;
  logic [BPCH_O-1:0] cr_o;
  logic              chroma_sel_o;

  // Handshake: a beat moves on a rising clk edge where valid && ready are both high.
  // A source holding valid must keep its data stable until the beat moves; ready may
  // depend on downstream state but never on the same side's valid.
  modport slave (
    input  in_valid_i, sol_i, mode_i, fmt422_i, r_i, g_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, sol_o, y_o, cb_o, cr_o, chroma_sel_o
  );
  modport master (
    output in_valid_i, sol_i, mode_i, fmt422_i, r_i, g_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, sol_o, y_o, cb_o, cr_o, chroma_sel_o
  );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// Three-stage RGB->YCbCr converter (BT.601/709, limited/full range, optional co-sited 4:2:2)
// with a single global stall driven by output backpressure.
`timescale 1ns/1ps
module rgb2ycbcr_pipe #(
  parameter int BPCH_I = 8,
  parameter int BPCH_O = 8
) (
  input logic            clk_i,
  input logic            rst_i,
  rgb2ycbcr_pipe_if.slave bus
);
  localparam int S  = 8 + BPCH_I - BPCH_O;
  localparam int PW = BPCH_I + 10;
  localparam int AW = BPCH_I + 12;

  typedef logic signed [8:0]    coef_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [AW-1:0] acc_t;

  // Offsets are pre-scaled by 2^S so they can join the sum before the final shift.
  localparam acc_t RND   = {{(AW-1){1'b0}}, 1'b1} << (S - 1);
  localparam acc_t OFF_Y = {{(AW-5){1'b0}}, 5'd16} << BPCH_I;
  localparam acc_t OFF_C = {{(AW-8){1'b0}}, 8'd128} << BPCH_I;
  localparam acc_t VMAX  = {{(AW-BPCH_O){1'b0}}, {BPCH_O{1'b1}}};

  function automatic prod_t mul(coef_t c, logic [BPCH_I-1:0] x);
    prod_t a;
    prod_t b;
    a = PW'(c);
    b = PW'(x);
    return a * b;
  endfunction

  function automatic logic [BPCH_O-1:0] clip(acc_t acc);
    acc_t v;
    v = acc >>> S;
    if (v[AW-1])      return '0;
    else if (v > VMAX) return '1;
    else               return v[BPCH_O-1:0];
  endfunction

  logic en;
  logic accept;
  assign en            = !(bus.out_valid_o && !bus.out_ready_i);
  assign bus.in_ready_o = en;
  assign accept        = bus.in_valid_i && en;

  // Coefficient order: Y(r,g,b), Cb(r,g,b), Cr(r,g,b).
  coef_t k [9];
  logic  full;
  always_comb begin
    k    = '{9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112, -9'sd94, -9'sd18};
    full = 1'b0;
    case (bus.mode_i)
      2'd1: k = '{9'sd47, 9'sd157, 9'sd16, -9'sd26, -9'sd86, 9'sd112, 9'sd112, -9'sd102, -9'sd10};
      2'd2: begin
        k    = '{9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21};
        full = 1'b1;
      end
      default: ;
    endcase
  end

  logic [BPCH_I-1:0] ch [3];
  assign ch[0] = bus.r_i;
  assign ch[1] = bus.g_i;
  assign ch[2] = bus.b_i;

  // A start-of-line pixel always takes the even chroma slot.
  logic parity;
  logic par_use;
  assign par_use = bus.sol_i ? 1'b0 : parity;

  logic  s1_valid, s1_sol, s1_fmt, s1_par, s1_full;
  prod_t p1 [9];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      parity   <= 1'b0;
      s1_valid <= 1'b0;
      s1_sol   <= 1'b0;
      s1_fmt   <= 1'b0;
      s1_par   <= 1'b0;
      s1_full  <= 1'b0;
      for (int i = 0; i < 9; i++) p1[i] <= '0;
    end else if (en) begin
      s1_valid <= accept;
      s1_sol   <= accept && bus.sol_i;
      s1_fmt   <= bus.fmt422_i;
      s1_par   <= par_use;
      s1_full  <= full;
      for (int i = 0; i < 9; i++) p1[i] <= mul(k[i], ch[i % 3]);
      if (accept) parity <= bus.fmt422_i ? !par_use : par_use;
    end
  end

  logic s2_valid, s2_sol, s2_fmt, s2_par;
  acc_t a_y, a_cb, a_cr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_sol   <= 1'b0;
      s2_fmt   <= 1'b0;
      s2_par   <= 1'b0;
      a_y      <= '0;
      a_cb     <= '0;
      a_cr     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sol   <= s1_sol;
      s2_fmt   <= s1_fmt;
      s2_par   <= s1_par;
      a_y  <= AW'(p1[0]) + AW'(p1[1]) + AW'(p1[2]) + RND + (s1_full ? acc_t'(0) : OFF_Y);
      a_cb <= AW'(p1[3]) + AW'(p1[4]) + AW'(p1[5]) + RND + OFF_C;
      a_cr <= AW'(p1[6]) + AW'(p1[7]) + AW'(p1[8]) + RND + OFF_C;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.out_valid_o  <= 1'b0;
      bus.sol_o        <= 1'b0;
      bus.y_o          <= '0;
      bus.cb_o         <= '0;
      bus.cr_o         <= '0;
      bus.chroma_sel_o <= 1'b0;
    end else if (en) begin
      bus.out_valid_o <= s2_valid;
      bus.sol_o       <= s2_sol;
      bus.y_o         <= clip(a_y);
      if (s2_fmt) begin
        bus.cb_o         <= s2_par ? clip(a_cr) : clip(a_cb);
        bus.cr_o         <= '0;
        bus.chroma_sel_o <= s2_par;
      end else begin
        bus.cb_o         <= clip(a_cb);
        bus.cr_o         <= clip(a_cr);
        bus.chroma_sel_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Directed + randomised-backpressure bench for rgb2ycbcr_pipe (8-bit in, 8-bit out).
`timescale 1ns/1ps
module tb_rgb2ycbcr_pipe;
  localparam int W = 26;  // {y, cb, cr, sol, sel}

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] mode;
    logic       fmt;
    logic       sol;
  } pix_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb2ycbcr_pipe_if #(.BPCH_I(8), .BPCH_O(8)) bus ();
  rgb2ycbcr_pipe #(.BPCH_I(8), .BPCH_O(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  pix_t           src_q[$];
  logic [W-1:0]   exp_q[$];
  int             total = 0;
  int             bad = 0;
  bit             model_par = 1'b0;
  int             first_acc, first_out, last_out;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic pix_t mk(int r, int g, int b, int mode, bit fmt, bit sol);
    pix_t p;
    p.r = 8'(r); p.g = 8'(g); p.b = 8'(b);
    p.mode = 2'(mode); p.fmt = fmt; p.sol = sol;
    return p;
  endfunction

  function automatic logic [7:0] conv8(int acc, int off);
    int v;
    v = ((acc + 128) >>> 8) + off;
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  // driver helpers
  task automatic hand(pix_t p, int y, int cb, int cr, bit sel);
    src_q.push_back(p);
    exp_q.push_back({8'(y), 8'(cb), 8'(cr), p.sol, sel});
  endtask

  task automatic push_model(pix_t p);
    int r, g, b, yo;
    int c [9];
    bit use_odd;
    logic [7:0] y, cb, cr;
    bit sel;
    r = p.r; g = p.g; b = p.b;
    case (p.mode)
      2'd1:    c = '{47, 157, 16, -26, -86, 112, 112, -102, -10};
      2'd2:    c = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
      default: c = '{66, 129, 25, -38, -74, 112, 112, -94, -18};
    endcase
    yo = (p.mode == 2'd2) ? 0 : 16;
    y  = conv8(c[0]*r + c[1]*g + c[2]*b, yo);
    cb = conv8(c[3]*r + c[4]*g + c[5]*b, 128);
    cr = conv8(c[6]*r + c[7]*g + c[8]*b, 128);
    use_odd = p.sol ? 1'b0 : model_par;
    if (p.fmt) begin
      sel = use_odd;
      model_par = !use_odd;
      if (use_odd) cb = cr;
      cr = 8'd0;
    end else begin
      sel = 1'b0;
      if (p.sol) model_par = 1'b0;
    end
    src_q.push_back(p);
    exp_q.push_back({y, cb, cr, p.sol, sel});
  endtask

  task automatic drive(pix_t p);
    bus.r_i = p.r; bus.g_i = p.g; bus.b_i = p.b;
    bus.mode_i = p.mode; bus.fmt422_i = p.fmt; bus.sol_i = p.sol;
  endtask

  task automatic run(bit rand_ready, int budget);
    bit           have;
    bit           hold;
    pix_t         cur;
    logic [W-1:0] held, obs, e;
    int           n;
    have = 1'b0; hold = 1'b0; n = 0;
    first_acc = -1; first_out = -1; last_out = -1;
    while ((have || src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
      bus.out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!have && src_q.size() > 0 && (!rand_ready || $urandom_range(0, 4) != 0)) begin
        cur  = src_q.pop_front();
        have = 1'b1;
      end
      bus.in_valid_i = have;
      if (have) drive(cur);
      else drive(mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1)));
      #1;
      obs = {bus.y_o, bus.cb_o, bus.cr_o, bus.sol_o, bus.chroma_sel_o};
      if (hold) begin
        check("stall_valid", bus.out_valid_o, 1);
        check("stall_data", obs, held);
        hold = 1'b0;
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        have = 1'b0;
        if (first_acc < 0) first_acc = n;
      end
      if (bus.out_valid_o) begin
        if (bus.out_ready_i) begin
          if (first_out < 0) first_out = n;
          last_out = n;
          if (exp_q.size() == 0) check("extra_out", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("y",   obs[25:18], e[25:18]);
            check("cb",  obs[17:10], e[17:10]);
            check("cr",  obs[9:2],   e[9:2]);
            check("sol", obs[1],     e[1]);
            check("sel", obs[0],     e[0]);
          end
        end else begin
          hold = 1'b1;
          held = obs;
        end
      end
    end
    if (n >= budget) begin
      check("timeout", 1, 0);
      src_q.delete();
      exp_q.delete();
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_par = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", bus.out_valid_o, 0);
    check("rst_y", bus.y_o, 0);
    check("rst_cb", bus.cb_o, 0);
    check("rst_cr", bus.cr_o, 0);
    check("rst_sol", bus.sol_o, 0);
    check("rst_sel", bus.chroma_sel_o, 0);
    check("rst_ready", bus.in_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;

    // back-to-back stream of hand-computed conversions
    hand(mk(0, 0, 0, 0, 0, 0),       16, 128, 128, 0);
    hand(mk(255, 255, 255, 0, 0, 0), 235, 128, 128, 0);
    hand(mk(255, 0, 0, 0, 0, 0),     82,  90,  240, 0);
    hand(mk(0, 255, 0, 1, 0, 1),     172, 42,  26,  0);
    hand(mk(0, 0, 255, 0, 0, 0),     41,  240, 110, 0);
    hand(mk(255, 255, 255, 2, 0, 0), 255, 128, 128, 0);
    hand(mk(255, 0, 0, 2, 0, 0),     77,  85,  255, 0);
    hand(mk(255, 0, 0, 3, 0, 0),     82,  90,  240, 0);
    run(1'b0, 100);
    check("latency", first_out - first_acc, 3);
    check("throughput", last_out - first_out, 7);

    // 4:2:2 line with sol mid-line on an odd slot
    hand(mk(255, 0, 0, 0, 1, 1), 82, 90,  0, 0);
    hand(mk(255, 0, 0, 0, 1, 0), 82, 240, 0, 1);
    hand(mk(255, 0, 0, 0, 1, 0), 82, 90,  0, 0);
    hand(mk(255, 0, 0, 0, 1, 0), 82, 240, 0, 1);
    hand(mk(255, 0, 0, 0, 1, 0), 82, 90,  0, 0);
    hand(mk(255, 0, 0, 0, 1, 1), 82, 90,  0, 0);
    hand(mk(255, 0, 0, 0, 1, 0), 82, 240, 0, 1);
    run(1'b0, 100);

    // random pixels and modes under random backpressure
    do_reset();
    for (int i = 0; i < 400; i++)
      push_model(mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7) == 0));
    run(1'b1, 6000);

    // reset with pixels in flight and parity odd
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1;
    drive(mk(255, 0, 0, 0, 1, 1));
    @(negedge clk);
    drive(mk(255, 0, 0, 0, 1, 0));
    @(negedge clk);
    drive(mk(255, 0, 0, 0, 1, 0));
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1;
    check("inflight_valid", bus.out_valid_o, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid_o, 0);
    check("arst_y", bus.y_o, 0);
    check("arst_cb", bus.cb_o, 0);
    check("arst_cr", bus.cr_o, 0);
    check("arst_sel", bus.chroma_sel_o, 0);
    check("arst_sol", bus.sol_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hand(mk(255, 0, 0, 0, 1, 0), 82, 90,  0, 0);
    hand(mk(255, 0, 0, 0, 1, 0), 82, 240, 0, 1);
    run(1'b0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
